// File: rtl/pulse_cmd_fifo.sv
// -----------------------------------------------------------------------------
// pulse_cmd_fifo
// Queues the 72-bit pulse commands that the processor core strobes out. The
// queue drains to the signal-generator element over a valid/ready handshake.
// A stalled element never loses a command that the queue accepted, and it
// never sees a command twice. Occupancy and a sticky overflow flag are
// reported to the control/status path.
//
// Optional feature: define CMD_TIMESTAMP_EN to stamp each accepted command
// with a free-running cycle counter and present the head stamp on ts_out.
//
// Ports:
//   clk          single clock for all logic
//   reset        asynchronous active-low reset (clears pointers, flags, counter)
//   cmd_in       command word from the core
//   cstrobe_in   one-cycle push qualifier for cmd_in
//   cmd_out      head-of-queue command, all-zero while cmd_valid=0
//   cmd_valid    head entry available
//   cmd_ready    element accepts head entry (pop on cmd_valid & cmd_ready)
//   level        number of stored entries, 0..2**DEPTH_LOG2
//   full         level == 2**DEPTH_LOG2
//   empty        level == 0
//   overflow     sticky: a strobed command was dropped
//   overflow_clr synchronous clear of overflow (a drop on the same edge wins)
//   ts_out       head entry timestamp (CMD_TIMESTAMP_EN only)
// -----------------------------------------------------------------------------
module pulse_cmd_fifo #(
  parameter int CMD_WIDTH  = 72,
  parameter int DEPTH_LOG2 = 3,
  parameter int TS_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic                  cstrobe_in,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  overflow_clr
`ifdef CMD_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]   ts_out
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Reject parameter values outside the supported range at elaboration.
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || TS_WIDTH < 1) begin : g_param_check
    $error("pulse_cmd_fifo: DEPTH_LOG2 must be 1..8 and TS_WIDTH >= 1");
  end

  logic [CMD_WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_r;
  logic [DEPTH_LOG2:0]   rd_ptr_r;
  logic                  overflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;

  // The pointers carry one extra wrap bit. When the low bits match, equal
  // wrap bits mean the queue is empty and different wrap bits mean it is full.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                   (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);

  assign pop_s  = !empty_s && cmd_ready;
  // When full, a strobe is accepted only if a pop frees a slot on the same edge.
  assign push_s = cstrobe_in && (!full_s || pop_s);
  assign drop_s = cstrobe_in && full_s && !pop_s;

  // Storage array, written on accepted pushes only; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= cmd_in;
    end
  end

  // Write and read pointers; both wrap naturally through the extra bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
    end
  end

  // Sticky overflow flag: a drop on the same edge overrides the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end
  end

  assign cmd_valid = !empty_s;
  assign cmd_out   = empty_s ? {CMD_WIDTH{1'b0}} : mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
  assign level     = wr_ptr_r - rd_ptr_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;

`ifdef CMD_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_r;
  logic [TS_WIDTH-1:0] ts_mem_r [DEPTH];

  // Free-running stamp counter; wraps to zero after all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt_r <= '0;
    end else begin
      ts_cnt_r <= ts_cnt_r + {{(TS_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Stamp storage: each accepted push records the counter value from before the edge.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ts_mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= ts_cnt_r;
    end
  end

  assign ts_out = empty_s ? {TS_WIDTH{1'b0}} : ts_mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
`endif

endmodule
